led_pattern_ctrl: RTL

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

---
 rtl/led_pattern_pkg.sv | 23 ++
 rtl/key_debounce.sv | 42 ++++
 rtl/led_pattern_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern controller.
// Mode encodings and the per-mode initial pattern.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_WALK   = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  // 32-bit wide; callers truncate to their LED count.
  function automatic logic [31:0] init_pattern(mode_e m);
    logic [31:0] p;
    case (m)
      MODE_STATIC: p = 32'h5555_5555;
      MODE_BLINK:  p = 32'h0000_0000;
      default:     p = 32'h0000_0001;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Counter debouncer with a one-cycle press pulse on an accepted 1->0.
// Ports: clk, rst_n, sample (synchronised key), press (pulse out).
module key_debounce
  import led_pattern_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  output logic press
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          level;

  // cnt counts differing samples seen so far minus one;
  // the DEBOUNCE_CYCLES-th consecutive one is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b1;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sample == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sample;
        press <= level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern generator with modes, pause and restart keys.
// Ports: CLOCK_50, RESET_N, KEY[1:0], SW[2:0] in; LED, PAUSED out.
module led_pattern_ctrl
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS        = 8,
  parameter int CLK_HZ          = 50000000,
  parameter int STEP_HZ         = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [1:0]          KEY,
  input  logic [2:0]          SW,
  output logic [NUM_LEDS-1:0] LED,
  output logic                PAUSED
);

  localparam int DIV_RAW  = CLK_HZ / STEP_HZ;
  localparam int TICK_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [1:0] key_m, key_s;
  logic [2:0] sw_m, sw_s;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_m <= 2'b11;
      key_s <= 2'b11;
      sw_m  <= 3'b000;
      sw_s  <= 3'b000;
    end else begin
      key_m <= KEY;
      key_s <= key_m;
      sw_m  <= SW;
      sw_s  <= sw_m;
    end
  end

  logic pause_press;
  logic restart_press;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_pause (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .sample(key_s[0]),
    .press (pause_press)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_restart (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .sample(key_s[1]),
    .press (restart_press)
  );

  logic [PW-1:0]       pre;
  logic [NUM_LEDS-1:0] pat;
  logic                dir_up;
  logic                first;
  mode_e               mode_q;

  mode_e               sw_mode;
  logic [NUM_LEDS-1:0] init_v;
  logic                reload;
  logic                wrap;
  logic                tick;

  assign sw_mode = mode_e'(sw_s[1:0]);
  assign init_v  = NUM_LEDS'(init_pattern(sw_mode));
  // first covers the load right after reset release
  assign reload  = first | (sw_mode != mode_q)
                 | restart_press;
  assign wrap    = (pre == PRE_LAST);
  assign tick    = wrap & ~PAUSED;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      LED    <= '0;
      PAUSED <= 1'b0;
      pre    <= '0;
      pat    <= '0;
      dir_up <= 1'b1;
      first  <= 1'b1;
      mode_q <= MODE_STATIC;
    end else begin
      LED <= pat;
      if (pause_press) PAUSED <= ~PAUSED;
      if (reload) begin
        first  <= 1'b0;
        mode_q <= sw_mode;
        pat    <= init_v;
        dir_up <= 1'b1;
        pre    <= '0;
      end else begin
        if (!PAUSED) pre <= wrap ? '0 : pre + PW'(1);
        if (tick) begin
          case (mode_q)
            MODE_STATIC: pat <= pat;
            MODE_WALK: begin
              if (sw_s[2])
                pat <= {pat[0], pat[NUM_LEDS-1:1]};
              else
                pat <= {pat[NUM_LEDS-2:0], pat[NUM_LEDS-1]};
            end
            MODE_BLINK: pat <= ~pat;
            MODE_BOUNCE: begin
              // turn around at either end, never past it
              if (dir_up) begin
                if (pat[NUM_LEDS-1]) begin
                  pat    <= pat >> 1;
                  dir_up <= 1'b0;
                end else begin
                  pat <= pat << 1;
                end
              end else begin
                if (pat[0]) begin
                  pat    <= pat << 1;
                  dir_up <= 1'b1;
                end else begin
                  pat <= pat >> 1;
                end
              end
            end
            default: pat <= pat;
          endcase
        end
      end
    end
  end

endmodule
